// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with x0 zero, write bypass, pending-write scoreboard, clear sequencer
module reg_file_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int AW     = $clog2(NREG),
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            reset,
  output logic            init_done,
  input  logic            WE3,
  input  logic [AW-1:0]   WA3,
  input  logic [XLEN-1:0] WD3,
  input  logic [AW-1:0]   RA1,
  input  logic [AW-1:0]   RA2,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  output logic            RDY1,
  output logic            RDY2,
  input  logic            alloc_en,
  input  logic [AW-1:0]   alloc_addr
);

  typedef enum logic {INIT, RUN} state_e;

  state_e          state_q;
  logic [AW-1:0]   idx_q;
  logic            init_done_q;
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [XLEN-1:0] rf [NREG];

  logic wr_en;
  logic al_en;

  assign wr_en = (state_q == RUN) && WE3 && (WA3 != '0);
  assign al_en = (state_q == RUN) && alloc_en && (alloc_addr != '0);

  // Alloc is applied after the write clear so a same-address alloc wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) busy_d[WA3] = 1'b0;
    if (al_en) busy_d[alloc_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= INIT;
      idx_q       <= '0;
      init_done_q <= 1'b0;
      busy_q      <= '0;
    end else begin
      busy_q <= busy_d;
      case (state_q)
        INIT: begin
          if (idx_q == AW'(NREG - 1)) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
          end else begin
            idx_q <= idx_q + AW'(1);
          end
        end
        RUN: ;
        default: state_q <= INIT;
      endcase
    end
  end

  // Array has no reset so it can map to distributed RAM; the sequencer clears it.
  always_ff @(posedge clk) begin
    if (state_q == INIT) rf[idx_q] <= '0;
    else if (wr_en)      rf[WA3]   <= WD3;
  end

  function automatic logic fwd(input logic [AW-1:0] ra);
    return (BYPASS != 0) && wr_en && (WA3 == ra);
  endfunction

  function automatic logic [XLEN-1:0] read_data(input logic [AW-1:0] ra);
    if (state_q != RUN || ra == '0) return '0;
    if (fwd(ra)) return WD3;
    return rf[ra];
  endfunction

  function automatic logic read_rdy(input logic [AW-1:0] ra);
    if (state_q != RUN) return 1'b0;
    if (ra == '0) return 1'b1;
    return !busy_q[ra] || fwd(ra);
  endfunction

  assign init_done = init_done_q;
  assign RD1       = read_data(RA1);
  assign RD2       = read_data(RA2);
  assign RDY1      = read_rdy(RA1);
  assign RDY2      = read_rdy(RA2);

endmodule
